mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/data width.
REQ-002 SHALL have parameter MAX_WAIT, default 15, meaning bus cycles allowed without mem_ready before abort.
REQ-003 SHALL have parameter STARVE_LIM, default 4, meaning consecutive data grants allowed while if_req waits.
REQ-004 SHALL use a single clock; reset is synchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 if_req  in  1  fetch request; if_addr  in  XLEN  fetch address.
REQ-008 if_gnt  out  1  fetch accepted; if_rvalid  out  1  fetch response; if_rdata  out  XLEN  fetch data.
REQ-009 dm_req  in  1; dm_we  in  1; dm_be  in  XLEN/8; dm_addr  in  XLEN; dm_wdata  in  XLEN  data-port request.
REQ-010 dm_gnt  out  1; dm_rvalid  out  1; dm_rdata  out  XLEN  data-port accept/response.
REQ-011 mem_req  out  1; mem_we  out  1; mem_be  out  XLEN/8; mem_addr  out  XLEN; mem_wdata  out  XLEN  shared bus request.
REQ-012 mem_ready  in  1; mem_rdata  in  XLEN  shared bus completion and read data.
REQ-013 flush  in  1  pipeline flush, kills fetch traffic.
REQ-014 if_stall_req  out  1; dm_stall_req  out  1  stall requests to pipeline control; bus_err  out  1  one-cycle abort pulse.

Function
REQ-015 SHALL implement FSM states IDLE, IF_BUSY, DM_BUSY; only one bus transaction outstanding.
REQ-016 In IDLE, winner SHALL receive combinational gnt in the same cycle; payload latched; state moves to *_BUSY next edge.
REQ-017 Priority: dm_req wins, except IF wins when starve counter equals STARVE_LIM and if_req is high.
REQ-018 Starve counter SHALL increment on each dm grant while if_req high, clear on any IF grant or when if_req low, saturate at STARVE_LIM.
REQ-019 In *_BUSY, mem_req and latched payload SHALL be held from registers until the cycle mem_ready is high; mem_we forced 0 for fetches, mem_be all-ones for fetches.
REQ-020 On mem_ready in *_BUSY, mem_rdata SHALL be registered and the matching rvalid pulses for one cycle next edge; state returns to IDLE on the same edge.
REQ-021 Minimum latency: grant cycle N, mem_req cycle N+1, ready at N+1 gives rvalid at N+2; new grant possible at N+2.
REQ-022 Requesters SHALL hold req and payload stable until gnt; arbiter SHALL NOT grant while not IDLE.
REQ-023 flush in IDLE SHALL suppress if_gnt that cycle; flush in IF_BUSY (including the mem_ready cycle) SHALL set a drop flag that suppresses the pending if_rvalid, bus transaction still completes.
REQ-024 flush SHALL NOT affect data-port transactions.
REQ-025 Wait counter SHALL count BUSY cycles without mem_ready; reaching MAX_WAIT SHALL drop mem_req, pulse bus_err and the matching rvalid with rdata 0 next edge, return to IDLE.
REQ-026 if_stall_req = if_req and not (if_rvalid); dm_stall_req = dm_req and not (dm_rvalid).
REQ-027 rdata outputs SHALL hold last value when rvalid low.

Reset
REQ-028 rst_n low at a clock edge SHALL force IDLE, clear counters and drop flag, all outputs 0 (mem_req, gnts, rvalids, rdata, bus_err), including mid-transaction; no rvalid follows an interrupted transaction.

Structure
REQ-029 XLEN default, FSM state enum and grant-source encoding SHALL reside in shared package riscv_pkg.
REQ-030 Wait counter/abort logic SHALL be sub-module bus_watchdog (start, ready, expire).

Verification
REQ-031 Simultaneous if_req/dm_req in IDLE, mem_ready immediate -> dm_gnt cycle 0, dm_rvalid cycle 2, if_gnt cycle 2, if_rvalid cycle 4.
REQ-032 dm_req held high for 6 transactions, if_req high -> IF granted after 4th data completion.
REQ-033 IF read 0x100, flush asserted in IF_BUSY, mem_ready after 3 cycles -> bus completes, no if_rvalid, next grant accepted.
REQ-034 mem_ready never asserted -> mem_req drops after 15 busy cycles, bus_err and rvalid pulse once, rdata 0.
REQ-035 Store dm_we=1 dm_be=0x3 addr 0x2000 wdata 0xDEADBEEF -> mem bus shows identical payload, dm_stall_req low after dm_rvalid.
REQ-036 rst_n low during DM_BUSY -> mem_req 0 next edge, no dm_rvalid, FSM IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the memory port arbiter: default width, FSM state
// encoding and the grant-source encoding used to steer the payload latch.
package riscv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_DM_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IF   = 2'd1,
    SRC_DM   = 2'd2
  } gnt_src_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every request/response/bus signal around the arbiter.
//
// Handshake: a requester raises *_req with its payload and holds both
// stable until the cycle *_gnt is high (combinational, same cycle); the
// request is consumed on that edge. Exactly one *_rvalid pulse later
// returns the response. On the shared bus, mem_req and its payload stay
// constant until the cycle mem_ready is high, which completes the transfer.
interface mem_port_arbiter_if
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [XLEN-1:0]   if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [XLEN/8-1:0] dm_be;
  logic [XLEN-1:0]   dm_addr;
  logic [XLEN-1:0]   dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [XLEN-1:0]   dm_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_rdata;

  logic              flush;
  logic              if_stall_req;
  logic              dm_stall_req;
  logic              bus_err;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
           mem_ready, mem_rdata, flush,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata,
           if_stall_req, dm_stall_req, bus_err
  );

  // Requester / memory side
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
           mem_ready, mem_rdata, flush,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata,
           if_stall_req, dm_stall_req, bus_err
  );

endinterface

// File: rtl/bus_watchdog.sv
// Counts busy bus cycles without mem_ready and flags expiry on the
// MAX_WAIT-th such cycle so the arbiter can abort the transfer.
module bus_watchdog #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic ready_i,
  output logic expire_o
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic          active_q;
  logic [CW-1:0] cnt_q;

  // cnt_q holds the number of earlier unanswered cycles of this transfer
  assign expire_o = active_q && !ready_i && (cnt_q == CW'(MAX_WAIT - 1));

  // Arm on grant, count waiting cycles, disarm on completion or expiry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
    end else if (active_q) begin
      if (ready_i || expire_o) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared
// memory bus with a single outstanding transaction, starvation relief for
// fetches, flush-based fetch dropping and a wait-timeout abort.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int MAX_WAIT   = 15,
  parameter int STARVE_LIM = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus,
  output arb_state_e           dbg_state_o
);
  localparam int            SW         = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  arb_state_e        state_q, state_d;
  gnt_src_e          gnt_src;
  logic [SW-1:0]     starve_q, starve_d;
  logic              drop_q, drop_d;
  logic              if_win, dm_win, busy, done, kill_if, wd_expire;

  logic              mem_we_q;
  logic [XLEN/8-1:0] mem_be_q;
  logic [XLEN-1:0]   mem_addr_q, mem_wdata_q;
  logic              if_rvalid_q, dm_rvalid_q, bus_err_q;
  logic [XLEN-1:0]   if_rdata_q, dm_rdata_q;

  // Data port normally wins; a starved fetch wins once the limit is hit.
  // A flush vetoes any fetch grant in that cycle.
  assign if_win  = rst_n && bus.if_req && !bus.flush &&
                   (!bus.dm_req || (starve_q == STARVE_MAX));
  assign dm_win  = rst_n && bus.dm_req && !if_win;
  assign busy    = (state_q != ST_IDLE);
  assign done    = busy && (bus.mem_ready || wd_expire);
  assign kill_if = drop_q || bus.flush;
  assign drop_d  = (state_q == ST_IF_BUSY) && !done && kill_if;

  // Next state and grant source; grants exist only in IDLE
  always_comb begin
    state_d = state_q;
    gnt_src = SRC_NONE;
    case (state_q)
      ST_IDLE: begin
        if (if_win) begin
          gnt_src = SRC_IF;
          state_d = ST_IF_BUSY;
        end else if (dm_win) begin
          gnt_src = SRC_DM;
          state_d = ST_DM_BUSY;
        end
      end
      ST_IF_BUSY, ST_DM_BUSY: begin
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Starvation counter: counts data grants that bypassed a waiting fetch
  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || (gnt_src == SRC_IF)) begin
      starve_d = '0;
    end else if ((gnt_src == SRC_DM) && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Payload latch, response registers, counters and the abort pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q    <= '0;
      drop_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      starve_q    <= starve_d;
      drop_q      <= drop_d;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      bus_err_q   <= wd_expire;
      if (gnt_src == SRC_IF) begin
        mem_we_q    <= 1'b0;
        mem_be_q    <= '1;
        mem_addr_q  <= bus.if_addr;
        mem_wdata_q <= '0;
      end else if (gnt_src == SRC_DM) begin
        mem_we_q    <= bus.dm_we;
        mem_be_q    <= bus.dm_be;
        mem_addr_q  <= bus.dm_addr;
        mem_wdata_q <= bus.dm_wdata;
      end
      // A flushed fetch still finishes on the bus but returns nothing
      if (done && (state_q == ST_IF_BUSY) && !kill_if) begin
        if_rvalid_q <= 1'b1;
        if_rdata_q  <= wd_expire ? '0 : bus.mem_rdata;
      end
      if (done && (state_q == ST_DM_BUSY)) begin
        dm_rvalid_q <= 1'b1;
        dm_rdata_q  <= wd_expire ? '0 : bus.mem_rdata;
      end
    end
  end

  bus_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (gnt_src != SRC_NONE),
    .ready_i  (bus.mem_ready),
    .expire_o (wd_expire)
  );

  assign bus.if_gnt       = (gnt_src == SRC_IF);
  assign bus.dm_gnt       = (gnt_src == SRC_DM);
  assign bus.mem_req      = busy;
  assign bus.mem_we       = busy && mem_we_q;
  assign bus.mem_be       = busy ? mem_be_q    : '0;
  assign bus.mem_addr     = busy ? mem_addr_q  : '0;
  assign bus.mem_wdata    = busy ? mem_wdata_q : '0;
  assign bus.if_rvalid    = if_rvalid_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.dm_rvalid    = dm_rvalid_q;
  assign bus.dm_rdata     = dm_rdata_q;
  assign bus.bus_err      = bus_err_q;
  assign bus.if_stall_req = bus.if_req && !if_rvalid_q;
  assign bus.dm_stall_req = bus.dm_req && !dm_rvalid_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge of the same cycle.
module tb_mem_port_arbiter;
  import riscv_pkg::*;

  localparam int XLEN = 32;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  arb_state_e dbg_state;
  int         n_vec = 0;
  int         n_err = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] exp_v;

  // Clock and reset
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.XLEN(XLEN)) bus();

  mem_port_arbiter #(
    .XLEN       (XLEN),
    .MAX_WAIT   (15),
    .STARVE_LIM (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver helpers
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_be     = '0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    bus.flush     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    mid();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_if_rvalid", bus.if_rvalid, 0);
    chk("rst_dm_rvalid", bus.dm_rvalid, 0);
    chk("rst_dm_rdata", bus.dm_rdata, 0);
    chk("rst_bus_err", bus.bus_err, 0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    next(); rst_n = 1'b1;
    next();

    // Simultaneous requests, immediate ready
    bus.if_req = 1; bus.if_addr = 32'h40; bus.dm_req = 1; bus.dm_addr = 32'h1000;
    bus.dm_be = 4'hF; bus.mem_ready = 1; bus.mem_rdata = 32'hAAAA0001;
    mid();
    chk("a0_dm_gnt", bus.dm_gnt, 1);
    chk("a0_if_gnt", bus.if_gnt, 0);
    chk("a0_if_stall", bus.if_stall_req, 1);
    next(); bus.dm_req = 0;
    mid();
    chk("a1_mem_req", bus.mem_req, 1);
    chk("a1_mem_addr", bus.mem_addr, 32'h1000);
    chk("a1_if_gnt", bus.if_gnt, 0);
    next(); bus.mem_rdata = 32'hBBBB0002;
    mid();
    chk("a2_dm_rvalid", bus.dm_rvalid, 1);
    chk("a2_dm_rdata", bus.dm_rdata, 32'hAAAA0001);
    chk("a2_if_gnt", bus.if_gnt, 1);
    chk("a2_mem_req", bus.mem_req, 0);
    next(); bus.if_req = 0;
    mid();
    chk("a3_mem_addr", bus.mem_addr, 32'h40);
    chk("a3_mem_be", bus.mem_be, 4'hF);
    chk("a3_mem_we", bus.mem_we, 0);
    chk("a3_if_rvalid", bus.if_rvalid, 0);
    next();
    mid();
    chk("a4_if_rvalid", bus.if_rvalid, 1);
    chk("a4_if_rdata", bus.if_rdata, 32'hBBBB0002);
    chk("a4_dm_rdata_hold", bus.dm_rdata, 32'hAAAA0001);
    chk("a4_dm_rvalid", bus.dm_rvalid, 0);
    next();
    mid();
    chk("a5_if_rvalid", bus.if_rvalid, 0);
    chk("a5_if_rdata_hold", bus.if_rdata, 32'hBBBB0002);

    // Store payload pass-through, back-to-back grant
    next();
    bus.mem_ready = 0; bus.mem_rdata = '0; bus.dm_req = 1; bus.dm_we = 1;
    bus.dm_be = 4'h3; bus.dm_addr = 32'h2000; bus.dm_wdata = 32'hDEADBEEF;
    mid();
    chk("b0_dm_gnt", bus.dm_gnt, 1);
    chk("b0_dm_stall", bus.dm_stall_req, 1);
    next(); bus.mem_ready = 1;
    mid();
    chk("b1_mem_req", bus.mem_req, 1);
    chk("b1_mem_we", bus.mem_we, 1);
    chk("b1_mem_be", bus.mem_be, 4'h3);
    chk("b1_mem_addr", bus.mem_addr, 32'h2000);
    chk("b1_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("b1_dm_gnt", bus.dm_gnt, 0);
    chk("b1_dm_stall", bus.dm_stall_req, 1);
    next();
    mid();
    chk("b2_dm_rvalid", bus.dm_rvalid, 1);
    chk("b2_dm_stall", bus.dm_stall_req, 0);
    chk("b2_dm_gnt", bus.dm_gnt, 1);
    next(); bus.dm_req = 0; bus.dm_we = 0;
    mid();
    chk("b3_mem_req", bus.mem_req, 1);
    next();
    mid();
    chk("b4_dm_rvalid", bus.dm_rvalid, 1);

    // Starvation relief: fetch wins after four data grants
    for (int c = 0; c <= 14; c++) begin
      next();
      if (c == 0) begin
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_be = 4'hF; bus.dm_addr = 32'h3000;
        bus.if_req = 1; bus.if_addr = 32'h80; bus.mem_ready = 1;
      end
      if (c == 9)  bus.if_req = 0;
      if (c == 13) bus.dm_req = 0;
      bus.mem_rdata = 32'h1000 + 32'(c);
      if (c % 2 == 1) exp_q.push_back(32'h1000 + 32'(c));
      mid();
      chk($sformatf("c%0d_if_gnt", c), bus.if_gnt, (c == 8) ? 1 : 0);
      chk($sformatf("c%0d_dm_gnt", c), bus.dm_gnt,
          ((c % 2 == 0) && (c <= 12) && (c != 8)) ? 1 : 0);
      if ((c >= 2) && (c % 2 == 0)) begin
        exp_v = exp_q.pop_front();
        if (c == 10) begin
          chk($sformatf("c%0d_if_rvalid", c), bus.if_rvalid, 1);
          chk($sformatf("c%0d_if_rdata", c), bus.if_rdata, exp_v);
          chk($sformatf("c%0d_dm_rvalid", c), bus.dm_rvalid, 0);
        end else begin
          chk($sformatf("c%0d_dm_rvalid", c), bus.dm_rvalid, 1);
          chk($sformatf("c%0d_dm_rdata", c), bus.dm_rdata, exp_v);
        end
      end
    end

    // Flush: in IDLE blocks the grant, in IF_BUSY drops the response
    next();
    bus.if_req = 1; bus.if_addr = 32'h100; bus.flush = 1; bus.mem_ready = 0;
    mid();
    chk("d0_if_gnt_flushed", bus.if_gnt, 0);
    next(); bus.flush = 0;
    mid();
    chk("d1_mem_req", bus.mem_req, 0);
    chk("d1_if_gnt", bus.if_gnt, 1);
    next(); bus.if_req = 0; bus.flush = 1;
    mid();
    chk("d2_mem_addr", bus.mem_addr, 32'h100);
    chk("d2_state", 64'(dbg_state), 64'(ST_IF_BUSY));
    next(); bus.flush = 0;
    mid();
    chk("d3_mem_req", bus.mem_req, 1);
    next();
    mid();
    chk("d4_mem_req", bus.mem_req, 1);
    next(); bus.mem_ready = 1; bus.mem_rdata = 32'h55;
    mid();
    chk("d5_mem_req", bus.mem_req, 1);
    next(); bus.mem_ready = 0; bus.if_req = 1; bus.if_addr = 32'h104;
    mid();
    chk("d6_if_rvalid_dropped", bus.if_rvalid, 0);
    chk("d6_if_rdata_hold", bus.if_rdata, 32'h1009);
    chk("d6_mem_req", bus.mem_req, 0);
    chk("d6_if_gnt", bus.if_gnt, 1);
    next(); bus.if_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h66;
    mid();
    chk("d7_mem_addr", bus.mem_addr, 32'h104);
    next();
    mid();
    chk("d8_if_rvalid", bus.if_rvalid, 1);
    chk("d8_if_rdata", bus.if_rdata, 32'h66);

    // Timeout abort after 15 busy cycles
    next();
    bus.mem_ready = 0; bus.dm_req = 1; bus.dm_addr = 32'h4000; bus.mem_rdata = 32'hFFFFFFFF;
    mid();
    chk("e0_dm_gnt", bus.dm_gnt, 1);
    next(); bus.dm_req = 0;
    for (int k = 1; k <= 15; k++) begin
      mid();
      chk($sformatf("e%0d_mem_req", k), bus.mem_req, 1);
      chk($sformatf("e%0d_bus_err", k), bus.bus_err, 0);
      next();
    end
    mid();
    chk("e16_mem_req", bus.mem_req, 0);
    chk("e16_bus_err", bus.bus_err, 1);
    chk("e16_dm_rvalid", bus.dm_rvalid, 1);
    chk("e16_dm_rdata", bus.dm_rdata, 0);
    next();
    mid();
    chk("e17_bus_err", bus.bus_err, 0);
    chk("e17_dm_rvalid", bus.dm_rvalid, 0);

    // Reset in the middle of a data transaction
    next();
    bus.dm_req = 1; bus.dm_addr = 32'h5000; bus.mem_ready = 0;
    mid();
    chk("f0_dm_gnt", bus.dm_gnt, 1);
    next(); bus.dm_req = 0;
    mid();
    chk("f1_mem_req", bus.mem_req, 1);
    next(); rst_n = 0;
    mid();
    chk("f2_state", 64'(dbg_state), 64'(ST_DM_BUSY));
    next(); rst_n = 1; bus.mem_ready = 1;
    mid();
    chk("f3_mem_req", bus.mem_req, 0);
    chk("f3_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("f3_dm_rvalid", bus.dm_rvalid, 0);
    chk("f3_if_rdata", bus.if_rdata, 0);
    next();
    mid();
    chk("f4_dm_rvalid", bus.dm_rvalid, 0);
    chk("f4_mem_req", bus.mem_req, 0);

    // Report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
